// File: rtl/mem_dualrail_if.sv
// Dual-rail memory request/response bundle.
// master drives requests, slave is the memory.
interface mem_dualrail_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [2*ADDR_W-1:0] addr_dr;
  logic [2*DATA_W-1:0] data_in_dr;
  logic [1:0]          op_dr;
  logic                ack_in_read;
  logic [2*DATA_W-1:0] data_out_dr;
  logic                ack_read;
  logic                ack_write;
  logic                err;

  modport master (
    output addr_dr, data_in_dr, op_dr,
    output ack_in_read,
    input  data_out_dr, ack_read,
    input  ack_write, err
  );

  modport slave (
    input  addr_dr, data_in_dr, op_dr,
    input  ack_in_read,
    output data_out_dr, ack_read,
    output ack_write, err
  );
endinterface

// File: rtl/mem_dualrail_sync.sv
// Clocked DEPTH x DATA_W memory behind a
// four-phase return-to-zero dual-rail interface.
module mem_dualrail_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input logic           clk,
  input logic           rst,
  mem_dualrail_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, WR_ACK, RD_VALID, RD_RTZ, ERR
  } state_e;

  localparam bit CHK = DEPTH < 2**ADDR_W;
  localparam logic [ADDR_W:0] LIM =
    (ADDR_W+1)'(DEPTH);

  state_e state_q, state_d;

  logic [1:0]          op_q;
  logic [2*ADDR_W-1:0] addr_q;
  logic [2*DATA_W-1:0] data_q;
  logic                ack_in_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [2*DATA_W-1:0] dout_q, dout_d;
  logic [2*DATA_W-1:0] enc;
  logic                ack_rd_q, ack_wr_q, err_q;

  logic [ADDR_W-1:0] addr_v;
  logic [DATA_W-1:0] wdata;
  logic addr_cmp, addr_ill;
  logic data_cmp, data_ill;
  logic op_cmp, op_ill, op_wr, op_rd;
  logic all_null, oor, we;

  always_comb begin
    addr_cmp = 1'b1;
    addr_ill = 1'b0;
    addr_v   = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      addr_v[i] = addr_q[2*i+1];
      addr_cmp &= addr_q[2*i+1] ^ addr_q[2*i];
      addr_ill |= &addr_q[2*i +: 2];
    end
  end

  always_comb begin
    data_cmp = 1'b1;
    data_ill = 1'b0;
    wdata    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      wdata[i] = data_q[2*i+1];
      data_cmp &= data_q[2*i+1] ^ data_q[2*i];
      data_ill |= &data_q[2*i +: 2];
    end
  end

  // Read word re-encoded as {b, ~b} per pair.
  always_comb begin
    enc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      enc[2*i+1] = mem_q[addr_v][i];
      enc[2*i]   = ~mem_q[addr_v][i];
    end
  end

  assign op_cmp   = ^op_q;
  assign op_ill   = &op_q;
  assign op_wr    = op_q == 2'b10;
  assign op_rd    = op_q == 2'b01;
  assign all_null = ~|op_q && ~|addr_q
                 && ~|data_q;
  assign oor      = CHK
                 && ({1'b0, addr_v} >= LIM);

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_ill || addr_ill ||
            (op_wr && data_ill)) begin
          state_d = ERR;
        end else if (op_cmp && addr_cmp
                     && oor) begin
          state_d = ERR;
        end else if (op_wr && addr_cmp
                     && data_cmp) begin
          we      = 1'b1;
          state_d = WR_ACK;
        end else if (op_rd && addr_cmp) begin
          dout_d  = enc;
          state_d = RD_VALID;
        end
      end
      WR_ACK: begin
        if (all_null) state_d = IDLE;
      end
      RD_VALID: begin
        if (ack_in_q && all_null) begin
          dout_d  = '0;
          state_d = RD_RTZ;
        end
      end
      RD_RTZ: begin
        if (!ack_in_q) state_d = IDLE;
      end
      ERR: begin
        if (all_null) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ack_in_q <= 1'b0;
      dout_q   <= '0;
      ack_rd_q <= 1'b0;
      ack_wr_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= bus.op_dr;
      addr_q   <= bus.addr_dr;
      data_q   <= bus.data_in_dr;
      ack_in_q <= bus.ack_in_read;
      dout_q   <= dout_d;
      ack_rd_q <= state_d == RD_VALID;
      ack_wr_q <= state_d == WR_ACK;
      err_q    <= state_d == ERR;
      if (we) mem_q[addr_v] <= wdata;
    end
  end

  assign bus.data_out_dr = dout_q;
  assign bus.ack_read    = ack_rd_q;
  assign bus.ack_write   = ack_wr_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_mem_dualrail_sync.sv
// Directed self-checking bench for
// mem_dualrail_sync.
module tb_mem_dualrail_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_dualrail_if #(
    .DATA_W(8), .ADDR_W(4)
  ) bus ();

  mem_dualrail_sync #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0]
    enc_a(input logic [3:0] a);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = a[i];
      r[2*i]   = ~a[i];
    end
    return r;
  endfunction

  function automatic logic [15:0]
    enc_d(input logic [7:0] d);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = d[i];
      r[2*i]   = ~d[i];
    end
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h",
        tag, obs, exp);
    end
  endtask

  task automatic nul();
    bus.op_dr      = 2'b00;
    bus.addr_dr    = '0;
    bus.data_in_dr = '0;
  endtask

  task automatic do_write(
    input logic [3:0] a,
    input logic [7:0] d);
    bus.op_dr      = 2'b10;
    bus.addr_dr    = enc_a(a);
    bus.data_in_dr = enc_d(d);
    cyc(2);
    chk("wr_ack", 16'(bus.ack_write), 1);
    nul();
    cyc(2);
    chk("wr_rtz", 16'(bus.ack_write), 0);
  endtask

  task automatic rd_close();
    nul();
    bus.ack_in_read = 1'b1;
    cyc(2);
    chk("rd_rtz_ack", 16'(bus.ack_read), 0);
    chk("rd_rtz_dat", bus.data_out_dr, 0);
    bus.ack_in_read = 1'b0;
    cyc(2);
  endtask

  task automatic do_read(
    input logic [3:0]  a,
    input logic [15:0] exp);
    bus.op_dr   = 2'b01;
    bus.addr_dr = enc_a(a);
    cyc(2);
    chk("rd_ack", 16'(bus.ack_read), 1);
    chk("rd_dat", bus.data_out_dr, exp);
    rd_close();
  endtask

  initial begin
    nul();
    bus.ack_in_read = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst_dout", bus.data_out_dr, 0);
    chk("rst_ackr", 16'(bus.ack_read), 0);
    chk("rst_ackw", 16'(bus.ack_write), 0);
    chk("rst_err",  16'(bus.err), 0);
    do_read(4'd5, 16'b0101010101010101);

    // Write 0xA5 to addr 3, edge-exact.
    bus.op_dr      = 2'b10;
    bus.addr_dr    = 8'b01011010;
    bus.data_in_dr = 16'b1001100101100110;
    cyc(1);
    chk("wa5_e1", 16'(bus.ack_write), 0);
    cyc(1);
    chk("wa5_e2", 16'(bus.ack_write), 1);
    cyc(3);
    chk("wa5_hold", 16'(bus.ack_write), 1);
    nul();
    cyc(1);
    chk("wa5_n1", 16'(bus.ack_write), 1);
    cyc(1);
    chk("wa5_n2", 16'(bus.ack_write), 0);

    // Read back, consumer holds off.
    bus.op_dr   = 2'b01;
    bus.addr_dr = 8'b01011010;
    cyc(2);
    chk("ra5_ack", 16'(bus.ack_read), 1);
    chk("ra5_dat", bus.data_out_dr,
        16'b1001100101100110);
    nul();
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("hold_ack", 16'(bus.ack_read), 1);
      chk("hold_dat", bus.data_out_dr,
          16'b1001100101100110);
    end
    bus.ack_in_read = 1'b1;
    cyc(2);
    chk("rel_ack", 16'(bus.ack_read), 0);
    chk("rel_dat", bus.data_out_dr, 0);
    bus.op_dr   = 2'b01;
    bus.addr_dr = 8'b01011010;
    cyc(5);
    chk("rtz_block", 16'(bus.ack_read), 0);
    bus.ack_in_read = 1'b0;
    cyc(2);
    chk("rtz_e2", 16'(bus.ack_read), 0);
    cyc(1);
    chk("rtz_e3", 16'(bus.ack_read), 1);
    chk("rtz_dat", bus.data_out_dr,
        16'b1001100101100110);
    rd_close();

    // Partial codeword: addr pair 0 null.
    bus.op_dr   = 2'b01;
    bus.addr_dr = 8'b01011000;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("part_wait", 16'(bus.ack_read), 0);
    end
    bus.addr_dr = 8'b01011010;
    cyc(1);
    chk("part_e1", 16'(bus.ack_read), 0);
    cyc(1);
    chk("part_e2", 16'(bus.ack_read), 1);
    chk("part_dat", bus.data_out_dr,
        16'b1001100101100110);
    rd_close();

    // Illegal op code.
    bus.op_dr      = 2'b11;
    bus.addr_dr    = 8'b01011010;
    bus.data_in_dr = enc_d(8'h3C);
    cyc(1);
    chk("iop_e1", 16'(bus.err), 0);
    cyc(1);
    chk("iop_err", 16'(bus.err), 1);
    cyc(3);
    chk("iop_hold", 16'(bus.err), 1);
    chk("iop_ackw", 16'(bus.ack_write), 0);
    nul();
    cyc(2);
    chk("iop_clr", 16'(bus.err), 0);
    do_read(4'd3, 16'b1001100101100110);

    // Illegal address pair during write.
    bus.op_dr      = 2'b10;
    bus.addr_dr    = 8'b01011011;
    bus.data_in_dr = enc_d(8'h3C);
    cyc(2);
    chk("iad_err", 16'(bus.err), 1);
    chk("iad_ackw", 16'(bus.ack_write), 0);
    nul();
    cyc(2);
    chk("iad_clr", 16'(bus.err), 0);
    do_read(4'd3, 16'b1001100101100110);

    // Reset while in RD_VALID.
    do_write(4'd7, 8'h77);
    bus.op_dr   = 2'b01;
    bus.addr_dr = enc_a(4'd7);
    cyc(2);
    chk("r7_dat", bus.data_out_dr,
        16'b0110101001101010);
    nul();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rstrd_dat", bus.data_out_dr, 0);
    chk("rstrd_ack", 16'(bus.ack_read), 0);

    // Reset while in WR_ACK.
    bus.op_dr      = 2'b10;
    bus.addr_dr    = enc_a(4'd2);
    bus.data_in_dr = enc_d(8'h11);
    cyc(2);
    chk("w2_ack", 16'(bus.ack_write), 1);
    nul();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rstwr_ack", 16'(bus.ack_write), 0);
    chk("rstwr_err", 16'(bus.err), 0);
    chk("rstwr_dat", bus.data_out_dr, 0);
    for (int a = 0; a < 16; a++)
      do_read(4'(a), 16'b0101010101010101);

    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end
endmodule
